uart_rx_word: RTL
=================

// Module: uart_rx_word
// PURPOSE
//   RS232 receive end of the PC<->FPGA command link. Deserialises 8N1 UART frames
//   from the PC and assembles NUM_BYTES consecutive bytes into one word.
//   The first byte received lands in word_out[7:0]. Each byte arrives LSB first.
//   This is the exact inverse of the word-transmit framing. The word is handed to
//   the RIS command decoder as a single-cycle word_valid strobe.
// PARAMETERS
//   CLKS_PER_BIT  434  clk cycles per bit time (50 MHz / 115200 baud); must be >= 8
//   NUM_BYTES     4    bytes per assembled word; word width = 8*NUM_BYTES
//   TIMEOUT_BITS  20   idle bit-times allowed between bytes of one word before abort
// PORTS
//   clk          in   1             system clock
//   reset        in   1             synchronous, active-high
//   rx           in   1             asynchronous serial line, idle high
//   word_out     out  8*NUM_BYTES   last complete word; held until next word completes
//   word_valid   out  1             1-cycle strobe: word_out updated this cycle
//   frame_err    out  1             1-cycle strobe: stop bit sampled low
//   timeout_err  out  1             1-cycle strobe: partial word discarded on inter-byte timeout
//   busy         out  1             high from start-bit detect until return to IDLE
// BEHAVIOUR
//   - Reset: word_out=0, word_valid=0, frame_err=0, timeout_err=0, busy=0.
//     Also: state=IDLE, byte_idx=0, both synchroniser FFs=1.
//     Reset mid-frame discards the partial byte and the partial word.
//   - rx passes through a 2-FF synchroniser. All logic uses the synchronised value rs.
//   - State machine:
//     IDLE: rs high->low edge: go to START, clear bit timer, busy=1.
//     START: at timer = CLKS_PER_BIT/2-1 (mid start bit), sample rs.
//       0: go to DATA, clear timer, bit_idx=0.
//       1: glitch; return to IDLE. byte_idx is unchanged; no error strobe.
//     DATA: every CLKS_PER_BIT cycles, sample rs into shift[bit_idx].
//       After bit_idx=7 is sampled, go to STOP.
//     STOP: after CLKS_PER_BIT cycles (mid stop bit), sample rs.
//       1: write the byte into word slot byte_idx and return to IDLE.
//         If byte_idx==NUM_BYTES-1: byte_idx=0, word_out and word_valid update
//         on the next clk edge (word_valid high for exactly 1 cycle).
//         Otherwise: byte_idx++.
//       0: frame_err=1 for 1 cycle, byte_idx=0, partial word dropped, go to BREAK.
//     BREAK: wait for rs=1, then go to IDLE. Prevents re-triggering on a held-low line.
//   - Back-to-back frames: return to IDLE at mid stop bit, so the next start edge
//     is caught with no extra idle time.
//   - Timeout: in IDLE with byte_idx!=0, count idle cycles. On reaching
//     TIMEOUT_BITS*CLKS_PER_BIT: timeout_err=1 for 1 cycle, byte_idx=0.
//     The counter clears on any start edge.
//   - word_valid latency: 1 clk after the final stop-bit sample, i.e. about
//     2 + 9.5*CLKS_PER_BIT + 1 cycles after the falling edge of the last start bit.
//   - Strobes are mutually exclusive. word_out never changes except with word_valid.
//   - Timer widths use $clog2 of their maximum count. No wrap inside a frame.
// STRUCTURE
//   - Shared header uart_defs.vh: state encodings (IDLE/START/DATA/STOP/BREAK),
//     default CLKS_PER_BIT, and the 8N1 frame constants (DATA_BITS=8, STOP_BITS=1).
//   - One natural sub-module: uart_rx_byte. It holds the synchroniser, the bit FSM
//     up to the stop sample, and outputs byte + byte_ok/byte_ferr strobes.
//     The top level holds byte_idx, word assembly, timeout and the output registers.
// TESTING (bench uses CLKS_PER_BIT=16, TIMEOUT_BITS=20)
//   1 Send 0x78,0x56,0x34,0x12 back-to-back -> word_out=0x12345678, one word_valid pulse, no errors.
//   2 Pulse rx low for 4 clks in IDLE -> no byte accepted, busy drops within 10 clks, no strobes.
//   3 Send 0xEF, then 0xBE with stop bit=0, hold rx high -> one frame_err pulse, no word_valid.
//     Then send 0xEF,0xBE,0xAD,0xDE -> word_out=0xDEADBEEF.
//   4 Send 0x11,0x22, idle 400 clks -> timeout_err pulse at 320 idle clks.
//     Then send 0x01,0x02,0x03,0x04 -> word_out=0x04030201.
//   5 Assert reset during DATA of byte 3 -> all outputs 0 next cycle.
//     Then send a full word 0xCAFEF00D -> word_out=0xCAFEF00D.
//   6 Send words 0x00000000 then 0xFFFFFFFF with zero inter-frame gap -> two word_valid
//     pulses with matching word_out, no frame_err.

Source files
------------

// File: rtl/uart_rx_word_pkg.sv
// Shared definitions for the UART word receiver: 8N1 frame constants, bit-FSM
// state encoding and the byte-level response record.
package uart_rx_word_pkg;

  localparam int DEF_CLKS_PER_BIT = 434;
  localparam int DATA_BITS        = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  // Strobes are valid in the cycle the deciding sample is taken.
  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 start;
    logic                 ok;
    logic                 ferr;
  } rx_byte_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_word_if.sv
// Serial input and assembled-word outputs of the UART word receiver.
interface uart_rx_word_if #(
  parameter int NUM_BYTES = 4
);
  logic                   rx;
  logic [8*NUM_BYTES-1:0] word_out;
  logic                   word_valid;
  logic                   frame_err;
  logic                   timeout_err;
  logic                   busy;

  modport master (
    input  rx,
    output word_out, word_valid, frame_err, timeout_err, busy
  );

  modport slave (
    output rx,
    input  word_out, word_valid, frame_err, timeout_err, busy
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte deserialiser: 2-FF synchroniser, start-edge detect and bit FSM up to
// the mid-stop-bit sample.
module uart_rx_byte
  import uart_rx_word_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     rx,
  output rx_byte_t rsp,
  output logic     busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF  = TW'(CLKS_PER_BIT/2 - 1);
  localparam logic [TW-1:0] FULL  = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LASTB = BW'(DATA_BITS - 1);

  logic [1:0] sync;
  logic       rs, rs_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync    <= 2'b11;
      rs_prev <= 1'b1;
    end else begin
      sync    <= {sync[0], rx};
      rs_prev <= sync[1];
    end
  end

  assign rs = sync[1];

  rx_state_t            state, state_nxt;
  logic [TW-1:0]        timer, timer_nxt;
  logic [BW-1:0]        bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer + 1'b1;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    rsp         = '0;
    rsp.data    = shift;
    case (state)
      ST_IDLE: begin
        timer_nxt = '0;
        if (rs_prev && !rs) begin
          state_nxt = ST_START;
          rsp.start = 1'b1;
        end
      end
      ST_START: begin
        if (timer == HALF) begin
          timer_nxt   = '0;
          bit_idx_nxt = '0;
          state_nxt   = rs ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (timer == FULL) begin
          timer_nxt          = '0;
          shift_nxt[bit_idx] = rs;
          if (bit_idx == LASTB) state_nxt = ST_STOP;
          else                  bit_idx_nxt = bit_idx + 1'b1;
        end
      end
      ST_STOP: begin
        // Leaving at mid stop bit lets a back-to-back start edge be caught.
        if (timer == FULL) begin
          timer_nxt = '0;
          if (rs) begin
            rsp.ok    = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            rsp.ferr  = 1'b1;
            state_nxt = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        timer_nxt = '0;
        if (rs) state_nxt = ST_IDLE;
      end
      default: begin
        timer_nxt = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: rtl/uart_rx_word.sv
// UART word receiver: assembles NUM_BYTES 8N1 bytes (first byte in the low slot)
// into one word, with frame-error and inter-byte timeout reporting.
module uart_rx_word
  import uart_rx_word_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int NUM_BYTES    = 4,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_word_if.master bus
);

  localparam int BI_W   = idx_w(NUM_BYTES);
  localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W   = $clog2(TO_CYC);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TO_CYC - 1);
  localparam logic [BI_W-1:0] LAST   = BI_W'(NUM_BYTES - 1);

  rx_byte_t rsp;
  logic     rx_busy;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk   (clk),
    .reset (reset),
    .rx    (bus.rx),
    .rsp   (rsp),
    .busy  (rx_busy)
  );

  logic [NUM_BYTES-1:0][7:0] slots, word_nxt, word_q;
  logic [BI_W-1:0]           byte_idx;
  logic [TO_W-1:0]           idle_cnt;
  logic                      word_valid, frame_err, timeout_err;

  always_comb begin
    word_nxt           = slots;
    word_nxt[byte_idx] = rsp.data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slots       <= '0;
      word_q      <= '0;
      byte_idx    <= '0;
      idle_cnt    <= '0;
      word_valid  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      word_valid  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;

      if (rsp.ok) begin
        slots <= word_nxt;
        if (byte_idx == LAST) begin
          byte_idx   <= '0;
          word_q     <= word_nxt;
          word_valid <= 1'b1;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end else if (rsp.ferr) begin
        byte_idx  <= '0;
        frame_err <= 1'b1;
      end

      // Counts only in IDLE with a partial word; ok/ferr occur while busy, so
      // the timeout branch never contends with them for byte_idx.
      if (rsp.start || rx_busy || byte_idx == '0) begin
        idle_cnt <= '0;
      end else if (idle_cnt == TO_MAX) begin
        idle_cnt    <= '0;
        byte_idx    <= '0;
        timeout_err <= 1'b1;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  assign bus.word_out    = word_q;
  assign bus.word_valid  = word_valid;
  assign bus.frame_err   = frame_err;
  assign bus.timeout_err = timeout_err;
  assign bus.busy        = rx_busy;

endmodule
